// File: rtl/forward_tracker.sv
// Forwarding-select and load-use stall generator for the RF-stage instruction.
// Keeps a two-slot history (EX, MEM) of destinations in flight and a saturating stall counter.
module forward_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rn,
  input  logic [4:0]       Rm,
  input  logic             UseRn,
  input  logic             UseRm,
  input  logic [4:0]       Rd,
  input  logic             RegWrite,
  input  logic             IsLoad,
  input  logic             Flush,
  output logic             FwdT1,
  output logic             FwdT2,
  output logic             FwdT3,
  output logic             FwdT4,
  output logic             Stall,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [4:0] XZR = 5'd31;

  logic       ex_v_reg, ex_wr_reg, ex_ld_reg;
  logic [4:0] ex_rd_reg;
  logic       mem_v_reg, mem_wr_reg, mem_ld_reg;
  logic [4:0] mem_rd_reg;
  logic [CNT_W-1:0] count_reg;

  logic ex_live, mem_live;
  logic hit_ex_n, hit_mem_n, hit_ex_m, hit_mem_m;
  logic stall_int;

  // XZR is excluded at the entry level so it can never match any source.
  assign ex_live  = ex_v_reg  & ex_wr_reg  & (ex_rd_reg  != XZR);
  assign mem_live = mem_v_reg & mem_wr_reg & (mem_rd_reg != XZR);

  assign hit_ex_n  = UseRn & ex_live  & (ex_rd_reg  == Rn);
  assign hit_mem_n = UseRn & mem_live & (mem_rd_reg == Rn);
  assign hit_ex_m  = UseRm & ex_live  & (ex_rd_reg  == Rm);
  assign hit_mem_m = UseRm & mem_live & (mem_rd_reg == Rm);

  assign stall_int = ex_ld_reg & (hit_ex_n | hit_ex_m);

  always_comb begin
    FwdT1 = 1'b0;
    FwdT2 = 1'b0;
    FwdT3 = 1'b0;
    FwdT4 = 1'b0;
    if (!stall_int) begin
      FwdT1 = hit_ex_n & ~ex_ld_reg;
      FwdT2 = hit_mem_n & ~hit_ex_n;
      FwdT3 = hit_ex_m & ~ex_ld_reg;
      FwdT4 = hit_mem_m & ~hit_ex_m;
    end
  end

  assign Stall      = stall_int;
  assign StallCount = count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v_reg   <= 1'b0;
      ex_wr_reg  <= 1'b0;
      ex_ld_reg  <= 1'b0;
      ex_rd_reg  <= 5'd0;
      mem_v_reg  <= 1'b0;
      mem_wr_reg <= 1'b0;
      mem_ld_reg <= 1'b0;
      mem_rd_reg <= 5'd0;
      count_reg  <= '0;
    end else begin
      mem_v_reg  <= ex_v_reg;
      mem_wr_reg <= ex_wr_reg;
      mem_ld_reg <= ex_ld_reg;
      mem_rd_reg <= ex_rd_reg;
      // A stalled or flushed instruction leaves a bubble behind in EX.
      if (!stall_int && !Flush) begin
        ex_v_reg  <= 1'b1;
        ex_wr_reg <= RegWrite;
        ex_ld_reg <= IsLoad;
        ex_rd_reg <= Rd;
      end else begin
        ex_v_reg  <= 1'b0;
        ex_wr_reg <= 1'b0;
        ex_ld_reg <= 1'b0;
        ex_rd_reg <= 5'd0;
      end
      if (stall_int && !(&count_reg)) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

endmodule
